// File: rtl/toggle_event_rx.sv
// toggle_event_rx: receive end of a toggle-signalling link.
// Synchronizes the toggle wire, turns each level change into one event,
// buffers events as a pending count behind a valid/ready handshake, and
// keeps a wrapping total plus a sticky overflow flag.
module toggle_event_rx #(
    parameter int CNT_W = 4,
    parameter int TOT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgl_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic [TOT_W-1:0] total,
    output logic             ovf,
    input  logic             clr_ovf
);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t     state;
    state_t     state_nx;
    logic [1:0] fill_cnt;
    logic       s1;
    logic       s2;
    logic       ref_lvl;
    logic       fill_done;
    logic       det;
    logic       dec;
    logic       full;

    // Two-flop synchronizer for the asynchronous toggle line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= tgl_in;
            s2 <= s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state: leave FILL once the synchronizer has flushed.
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (fill_done) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = FILL;
        endcase
    end

    // FSM outputs: end-of-fill strobe and event detect.
    always_comb begin
        fill_done = (state == FILL) && (fill_cnt == 2'd1);
        det       = (state == RUN) && (s2 != ref_lvl);
    end

    // Fill counter, counts the FILL edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt <= 2'd0;
        end else if (state == FILL) begin
            fill_cnt <= fill_cnt + 2'd1;
        end
    end

    // Reference level. At the end of FILL it takes the value s2 is loading
    // on that same edge (s1), so a level held across reset release never
    // shows up as a difference once RUN starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_lvl <= 1'b0;
        end else if (fill_done) begin
            ref_lvl <= s1;
        end else if (det) begin
            ref_lvl <= s2;
        end
    end

    // Handshake and capacity decode.
    always_comb begin
        dec  = evt_valid && evt_ready;
        full = (pending == PEND_MAX);
    end

    assign evt_valid = (pending != '0);

    // Pending event counter; saturates at capacity, never underflows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (det && !dec) begin
            if (!full) pending <= pending + CNT_W'(1);
        end else if (!det && dec) begin
            pending <= pending - CNT_W'(1);
        end
    end

    // Wrapping total of detected events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total <= '0;
        end else if (det) begin
            total <= total + TOT_W'(1);
        end
    end

    // Sticky overflow; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (det && !dec && full) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed testbench for toggle_event_rx. A default instance (TOT_W=16)
// and a narrow-total instance (TOT_W=4) share the same stimulus.
module tb_toggle_event_rx;

    logic        clk;
    logic        rst_n;
    logic        tgl_in;
    logic        evt_ready;
    logic        clr_ovf;

    logic        evt_valid;
    logic [3:0]  pending;
    logic [15:0] total;
    logic        ovf;

    logic        w_evt_valid;
    logic [3:0]  w_pending;
    logic [3:0]  w_total;
    logic        w_ovf;

    int passes = 0;
    int checks = 0;

    toggle_event_rx u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgl_in    (tgl_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pending   (pending),
        .total     (total),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    toggle_event_rx #(
        .CNT_W (4),
        .TOT_W (4)
    ) u_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgl_in    (tgl_in),
        .evt_valid (w_evt_valid),
        .evt_ready (evt_ready),
        .pending   (w_pending),
        .total     (w_total),
        .ovf       (w_ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Flip the line and hold it 3 cycles (detection lands on the 3rd edge).
    task automatic toggle3();
        tgl_in = ~tgl_in;
        step(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        tgl_in    = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset state with the line held high.
        step(3);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // Release; the held high level must not become an event.
        rst_n = 1'b1;
        step(10);
        chk("idle_pending", 32'(pending), 0);
        chk("idle_total", 32'(total), 0);
        chk("idle_valid", 32'(evt_valid), 0);

        // Three toggles, 4 cycles apart; update exactly at edge N+2.
        for (int k = 1; k <= 3; k++) begin
            tgl_in = ~tgl_in;
            step(1);
            chk("lat_n_pending", 32'(pending), 32'(k - 1));
            step(1);
            chk("lat_n1_pending", 32'(pending), 32'(k - 1));
            chk("lat_n1_total", 32'(total), 32'(k - 1));
            step(1);
            chk("lat_n2_pending", 32'(pending), 32'(k));
            chk("lat_n2_total", 32'(total), 32'(k));
            step(1);
        end
        chk("three_valid", 32'(evt_valid), 1);

        // Drain one per cycle.
        evt_ready = 1'b1;
        step(1);
        chk("drain_2", 32'(pending), 2);
        step(1);
        chk("drain_1", 32'(pending), 1);
        chk("drain_1_valid", 32'(evt_valid), 1);
        step(1);
        chk("drain_0", 32'(pending), 0);
        chk("drain_0_valid", 32'(evt_valid), 0);
        step(1);
        chk("no_underflow", 32'(pending), 0);
        evt_ready = 1'b0;

        // Fill to capacity: 15 events fit, the 16th overflows.
        for (int k = 0; k < 15; k++) toggle3();
        chk("full_pending", 32'(pending), 15);
        chk("full_ovf_clear", 32'(ovf), 0);
        toggle3();
        chk("ovf_pending", 32'(pending), 15);
        chk("ovf_total", 32'(total), 19);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_w_total", 32'(w_total), 3);
        step(2);
        chk("ovf_sticky", 32'(ovf), 1);

        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_pending", 32'(pending), 15);

        // Drain to 3, then a detection coincides with a consume at 1.
        evt_ready = 1'b1;
        step(12);
        chk("pre_coinc", 32'(pending), 3);
        tgl_in = ~tgl_in;
        step(2);
        chk("coinc_before", 32'(pending), 1);
        step(1);
        chk("coinc_pending", 32'(pending), 1);
        chk("coinc_total", 32'(total), 20);
        step(1);
        chk("coinc_drained", 32'(pending), 0);
        evt_ready = 1'b0;

        // Pending=5, narrow total=9, then a 1-cycle reset with toggling.
        for (int k = 0; k < 5; k++) toggle3();
        chk("pre_rst_pending", 32'(pending), 5);
        chk("pre_rst_w_total", 32'(w_total), 9);
        tgl_in = ~tgl_in;
        rst_n  = 1'b0;
        step(1);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_total", 32'(total), 0);
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_w_total", 32'(w_total), 0);
        rst_n  = 1'b1;
        tgl_in = ~tgl_in;
        step(6);
        chk("fill_absorb_pending", 32'(pending), 0);
        chk("fill_absorb_total", 32'(total), 0);
        toggle3();
        chk("post_fill_pending", 32'(pending), 1);
        chk("post_fill_total", 32'(total), 1);

        // 16 more toggles while draining: narrow total wraps to 1.
        evt_ready = 1'b1;
        step(1);
        for (int k = 0; k < 16; k++) toggle3();
        step(1);
        chk("wrap_w_total", 32'(w_total), 1);
        chk("wrap_total", 32'(total), 17);
        chk("wrap_ovf", 32'(ovf), 0);
        chk("wrap_w_ovf", 32'(w_ovf), 0);
        chk("wrap_pending", 32'(pending), 0);
        chk("wrap_w_valid", 32'(w_evt_valid), 0);
        chk("wrap_w_pending", 32'(w_pending), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
